// File: rtl/mcmem_arbiter.sv
// mcmem_arbiter: fetch/data arbiter and wait-state sequencer for the unified memory.
// Define MCMEM_ARB_RR_EN for round-robin tie breaking; default is data-over-fetch priority.
`timescale 1ns/1ps
module mcmem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        own_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        grant_d;
    logic        busy;
    logic        last_cyc;

`ifdef MCMEM_ARB_RR_EN
    logic last_d;

    // On a tie, hand the grant to whoever was not served last.
    assign grant_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (i_req | d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign busy     = (state == BUSY);
    assign last_cyc = busy & (cnt == 4'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            own_d   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state   <= BUSY;
                        own_d   <= grant_d;
                        we_q    <= grant_d & d_we;
                        addr_q  <= grant_d ? d_addr : i_addr;
                        wdata_q <= grant_d ? d_wdata : '0;
                        cnt     <= WAIT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        // Writes leave both read registers untouched.
                        if (!we_q) begin
                            if (own_d) begin
                                d_rdata <= mem_dataout;
                            end else begin
                                i_rdata <= mem_dataout;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = busy ? addr_q : '0;
    assign mem_datain = busy ? wdata_q : '0;
    assign mem_we     = last_cyc & we_q;

    assign i_ack = (state == DONE) & ~own_d;
    assign d_ack = (state == DONE) & own_d;

endmodule

// File: tb/tb_mcmem_arbiter.sv
// tb_mcmem_arbiter: three arbiters (WAIT_CYCLES 1, 0, 3) each with its own memory,
// checked every cycle against a transaction-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_mcmem_arbiter;

    localparam int N = 3;
`ifdef MCMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn       [N];
    logic        i_req      [N];
    logic        d_req      [N];
    logic        d_we       [N];
    logic        i_ack      [N];
    logic        d_ack      [N];
    logic        mem_we     [N];
    logic [31:0] i_addr     [N];
    logic [31:0] i_rdata    [N];
    logic [31:0] d_addr     [N];
    logic [31:0] d_wdata    [N];
    logic [31:0] d_rdata    [N];
    logic [31:0] mem_addr   [N];
    logic [31:0] mem_datain [N];
    logic [31:0] mem        [N][64];

    int passed = 0;
    int total  = 0;

    function automatic int wc(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic bit pick_d(bit i, bit d, bit last);
        return d && (!i || !RR || !last);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mcmem_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))) dut (
            .clk         (clk),
            .clrn        (clrn[g]),
            .i_req       (i_req[g]),
            .i_addr      (i_addr[g]),
            .i_rdata     (i_rdata[g]),
            .i_ack       (i_ack[g]),
            .d_req       (d_req[g]),
            .d_we        (d_we[g]),
            .d_addr      (d_addr[g]),
            .d_wdata     (d_wdata[g]),
            .d_rdata     (d_rdata[g]),
            .d_ack       (d_ack[g]),
            .mem_addr    (mem_addr[g]),
            .mem_datain  (mem_datain[g]),
            .mem_we      (mem_we[g]),
            .mem_dataout (mem[g][mem_addr[g][7:2]])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_we[k]) mem[k][mem_addr[k][7:2]] <= mem_datain[k];
        end
    end

    // Model: left = busy cycles still to run; 0 = ack cycle; -1 = idle.
    int          left   [N];
    bit          m_d    [N];
    bit          m_we   [N];
    bit          last_d [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd   [N];
    logic [31:0] m_ir   [N];
    logic [31:0] m_dr   [N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!clrn[k]) begin
                left[k]   <= -1;
                last_d[k] <= 1'b0;
                m_ir[k]   <= '0;
                m_dr[k]   <= '0;
            end else if (left[k] == 0) begin
                left[k] <= -1;
            end else if (left[k] > 0) begin
                left[k] <= left[k] - 1;
                if (left[k] == 1 && !m_we[k]) begin
                    if (m_d[k]) m_dr[k] <= mem[k][m_addr[k][7:2]];
                    else m_ir[k] <= mem[k][m_addr[k][7:2]];
                end
            end else if (i_req[k] || d_req[k]) begin
                m_d[k]    <= pick_d(i_req[k], d_req[k], last_d[k]);
                last_d[k] <= pick_d(i_req[k], d_req[k], last_d[k]);
                m_we[k]   <= pick_d(i_req[k], d_req[k], last_d[k]) && d_we[k];
                m_addr[k] <= pick_d(i_req[k], d_req[k], last_d[k]) ? d_addr[k] : i_addr[k];
                m_wd[k]   <= pick_d(i_req[k], d_req[k], last_d[k]) ? d_wdata[k] : 32'h0;
                left[k]   <= wc(k) + 1;
            end
        end
    end

    int          n_iack [N];
    int          n_dack [N];
    int          n_we   [N];
    logic [7:0]  order  [$];

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!clrn[k]) begin
                chk($sformatf("rst_iack%0d", k), i_ack[k], 0);
                chk($sformatf("rst_dack%0d", k), d_ack[k], 0);
                chk($sformatf("rst_we%0d", k), mem_we[k], 0);
                chk($sformatf("rst_addr%0d", k), mem_addr[k], 0);
                chk($sformatf("rst_din%0d", k), mem_datain[k], 0);
            end else begin
                chk($sformatf("iack%0d", k), i_ack[k], left[k] == 0 && !m_d[k]);
                chk($sformatf("dack%0d", k), d_ack[k], left[k] == 0 && m_d[k]);
                chk($sformatf("we%0d", k), mem_we[k], left[k] == 1 && m_we[k]);
                chk($sformatf("addr%0d", k), mem_addr[k], left[k] > 0 ? m_addr[k] : 0);
                chk($sformatf("din%0d", k), mem_datain[k], left[k] > 0 ? m_wd[k] : 0);
                chk($sformatf("irdata%0d", k), i_rdata[k], m_ir[k]);
                chk($sformatf("drdata%0d", k), d_rdata[k], m_dr[k]);
            end
            if (i_ack[k]) n_iack[k] <= n_iack[k] + 1;
            if (d_ack[k]) n_dack[k] <= n_dack[k] + 1;
            if (mem_we[k]) n_we[k] <= n_we[k] + 1;
        end
        if (d_ack[0]) order.push_back("D");
        if (i_ack[0]) order.push_back("I");
    end

    // Call #1 after an edge; returns edges counted from the grant edge to the ack edge.
    task automatic access(input int k, input bit isd, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int edges);
        edges = 0;
        if (isd) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = a;
        end
        while (edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            if (isd ? d_ack[k] : i_ack[k]) break;
        end
        if (isd) d_req[k] = 1'b0;
        else i_req[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        int base;
        int na;
        int nw;
        for (int k = 0; k < N; k++) begin
            clrn[k] = 1'b0; i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
            for (int i = 0; i < 64; i++) mem[k][i] <= 32'h0;
            mem[k][1]  <= 32'h34240080;
            mem[k][34] <= 32'h39085555;
        end
        mem[0][35] <= 32'h0badf00d;
        mem[0][36] <= 32'h12345678;
        mem[2][16] <= 32'haaaa5555;

        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            chk("reset_irdata", i_rdata[k], 0);
            chk("reset_drdata", d_rdata[k], 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) clrn[k] = 1'b1;
        @(posedge clk); #1;

        // 1: fetch with one wait state
        nw = n_we[0];
        access(0, 0, 0, 32'h4, 32'h0, e);
        chk("t1_latency", e, 3);
        chk("t1_ack", i_ack[0], 1);
        chk("t1_rdata", i_rdata[0], 32'h34240080);
        @(posedge clk); #1;
        chk("t1_ack_drop", i_ack[0], 0);
        chk("t1_no_we", n_we[0] - nw, 0);
        chk("t1_drdata", d_rdata[0], 0);

        // 2: write then read back
        nw = n_we[0];
        access(0, 1, 1, 32'h80, 32'hdeadbeef, e);
        chk("t2_wr_latency", e, 3);
        chk("t2_drdata_kept", d_rdata[0], 0);
        @(posedge clk); #1;
        chk("t2_we_pulses", n_we[0] - nw, 1);
        chk("t2_mem", mem[0][32], 32'hdeadbeef);
        access(0, 1, 0, 32'h80, 32'h0, e);
        chk("t2_rd", d_rdata[0], 32'hdeadbeef);
        @(posedge clk); #1;

        // 3: both requesters contend for four grants
        base = order.size();
        fork
            begin
                int e1;
                for (int j = 0; j < 2; j++) begin
                    access(0, 1, 0, 32'h88, 32'h0, e1);
                    @(posedge clk); #1;
                end
            end
            begin
                int e2;
                for (int j = 0; j < 2; j++) begin
                    access(0, 0, 0, 32'h4, 32'h0, e2);
                    @(posedge clk); #1;
                end
            end
        join
        chk("t3_count", order.size() - base, 4);
        if (order.size() - base >= 4) begin
            chk("t3_g0", {24'h0, order[base]},     "D");
            chk("t3_g1", {24'h0, order[base + 1]}, RR ? "I" : "D");
            chk("t3_g2", {24'h0, order[base + 2]}, RR ? "D" : "I");
            chk("t3_g3", {24'h0, order[base + 3]}, "I");
        end

        // 4: zero wait states
        access(1, 1, 0, 32'h88, 32'h0, e);
        chk("t4_latency", e, 2);
        chk("t4_rdata", d_rdata[1], 32'h39085555);
        @(posedge clk); #1;

        // 5: reset during a write
        na = n_dack[2];
        nw = n_we[2];
        d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 32'h40; d_wdata[2] = 32'h11111111;
        @(posedge clk); #1;
        chk("t5_granted", mem_addr[2], 32'h40);
        clrn[2] = 1'b0;
        #1;
        chk("t5_addr0", mem_addr[2], 0);
        chk("t5_din0", mem_datain[2], 0);
        chk("t5_we0", mem_we[2], 0);
        chk("t5_ack0", d_ack[2], 0);
        d_req[2] = 1'b0; d_we[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_mem", mem[2][16], 32'haaaa5555);
        chk("t5_no_ack", n_dack[2] - na, 0);
        chk("t5_no_we", n_we[2] - nw, 0);
        access(2, 1, 0, 32'h40, 32'h0, e);
        chk("t5_latency", e, 5);
        chk("t5_rd", d_rdata[2], 32'haaaa5555);
        @(posedge clk); #1;

        // 6: request dropped and address changed after grant
        na = n_dack[0];
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h8c;
        @(posedge clk); #1;
        d_addr[0] = 32'h90; d_req[0] = 1'b0;
        e = 0;
        while (e < 40 && !d_ack[0]) begin
            @(posedge clk); #1;
            e++;
        end
        chk("t6_ack", d_ack[0], 1);
        chk("t6_rdata", d_rdata[0], 32'h0badf00d);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_one_ack", n_dack[0] - na, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
